// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: digit width, BCD limit,
// FSM state encoding and the per-digit clamp helper.
package timer_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the countdown chain: loads, reloads or decrements with
// 0 -> 9 wrap. The borrow decision is made by the top level.
module bcd_digit_cell
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec_en,
  input  logic               reload_en,
  output logic [DIGIT_W-1:0] digit,
  output logic               is_zero
);
  always_ff @(posedge clk) begin
    if (rst)
      digit <= '0;
    else if (load || reload_en)
      digit <= load_val;
    else if (dec_en)
      digit <= (digit == '0) ? BCD_MAX : digit - 1'b1;
  end

  assign is_zero = (digit == '0);
endmodule

// File: rtl/bcd_countdown_timer.sv
// Cascaded BCD countdown timer: FSM, preset register, borrow chain and
// expiry detect around NUM_DIGITS digit cells.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  input  logic                          dec,
  input  logic                          hold,
  output logic [DIGIT_W*NUM_DIGITS-1:0] value_out,
  output logic                          running,
  output logic                          timeout,
  output logic                          expired
);
  state_t state_q, state_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] load_clamp, preset_q, cell_val, digit_q;
  logic [NUM_DIGITS-1:0] is_zero, lower_zero, dec_en, one_chk;
  logic accept, cnt_is_one, expire, reload_en, load_nz, timeout_q;

  // Load wins over dec, so a coincident dec never reaches the chain.
  assign accept    = dec & ~hold & ~load & (state_q == ST_RUN);
  assign expire    = accept & cnt_is_one;
  assign reload_en = expire & (AUTO_RELOAD != 0);
  assign load_nz   = |load_clamp;

  always_comb begin
    one_chk    = is_zero;
    one_chk[0] = (digit_q[0] == 4'd1);
    cnt_is_one = &one_chk;
  end

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      assign load_clamp[k] = bcd_clamp(value_in[k*DIGIT_W +: DIGIT_W]);
      if (k == 0) begin : g_lsd
        assign lower_zero[k] = 1'b1;
      end else begin : g_upper
        assign lower_zero[k] = lower_zero[k-1] & is_zero[k-1];
      end
      assign dec_en[k]   = accept & ~reload_en & lower_zero[k];
      assign cell_val[k] = load ? load_clamp[k] : preset_q[k];

      bcd_digit_cell u_cell (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (cell_val[k]),
        .dec_en    (dec_en[k]),
        .reload_en (reload_en),
        .digit     (digit_q[k]),
        .is_zero   (is_zero[k])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = load_nz ? ST_RUN : ST_EXPIRED;
    else if (expire)
      state_d = (AUTO_RELOAD != 0) ? ST_RUN : ST_EXPIRED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      preset_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= expire;
      if (load)
        preset_q <= load_clamp;
    end
  end

  assign value_out = digit_q;
  assign running   = (state_q == ST_RUN);
  assign expired   = (state_q == ST_EXPIRED);
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed plus randomized check of both reload modes against an integer
// countdown model.
module tb_bcd_countdown_timer;
  localparam int ND = 4;
  localparam int W  = 4*ND;

  logic clk = 1'b0;
  logic rst, load, dec, hold;
  logic [W-1:0] value_in;
  logic [W-1:0] vo [2];
  logic run_o [2], to_o [2], exp_o [2];

  int m_cnt [2], m_pre [2];
  bit m_run [2], m_exp [2], m_to [2];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.NUM_DIGITS(ND), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dec(dec), .hold(hold),
    .value_out(vo[0]), .running(run_o[0]), .timeout(to_o[0]), .expired(exp_o[0]));
  bcd_countdown_timer #(.NUM_DIGITS(ND), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dec(dec), .hold(hold),
    .value_out(vo[1]), .running(run_o[1]), .timeout(to_o[1]), .expired(exp_o[1]));

  function automatic int bcd2int(input logic [W-1:0] v);
    int n, acc, scale;
    acc = 0; scale = 1;
    for (int i = 0; i < ND; i++) begin
      n = int'(v[i*4 +: 4]);
      if (n > 9) n = 9;
      acc += n * scale;
      scale *= 10;
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_step(input int i, input bit auto_rl);
    int v;
    v = bcd2int(value_in);
    m_to[i] = 1'b0;
    if (rst) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_run[i] = 0; m_exp[i] = 0;
    end else if (load) begin
      m_cnt[i] = v; m_pre[i] = v; m_run[i] = (v != 0); m_exp[i] = (v == 0);
    end else if (dec && !hold && m_run[i]) begin
      if (m_cnt[i] == 1) begin
        m_to[i] = 1'b1;
        if (auto_rl) m_cnt[i] = m_pre[i];
        else begin m_cnt[i] = 0; m_run[i] = 0; m_exp[i] = 1; end
      end else
        m_cnt[i] = m_cnt[i] - 1;
    end
  endtask

  task automatic step(input bit r, input bit ld, input logic [W-1:0] v, input bit d, input bit h);
    rst = r; load = ld; value_in = v; dec = d; hold = h;
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    vectors++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("value_out[%0d]", i), 32'(vo[i]), 32'(int2bcd(m_cnt[i])));
      chk($sformatf("running[%0d]", i), 32'(run_o[i]), 32'(m_run[i]));
      chk($sformatf("timeout[%0d]", i), 32'(to_o[i]), 32'(m_to[i]));
      chk($sformatf("expired[%0d]", i), 32'(exp_o[i]), 32'(m_exp[i]));
    end
  endtask

  initial begin
    logic [W-1:0] rv;
    int to_cnt;
    rst = 1'b1; load = 1'b0; dec = 1'b0; hold = 1'b0; value_in = '0;
    step(1, 0, 16'h0000, 0, 0);
    step(1, 1, 16'h0055, 1, 0);
    chk("reset_value", 32'(vo[0]), 32'h0);

    // Twelve decs from 0012 down to expiry
    step(0, 1, 16'h0012, 0, 0);
    to_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 16'h0000, 1, 0);
      to_cnt += int'(to_o[0]);
    end
    chk("expire_value", 32'(vo[0]), 32'h0);
    chk("expire_pulses", 32'(to_cnt), 32'd1);

    // Expired: decs ignored, zero load, then load with coincident dec
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 1, 0);
    step(0, 1, 16'h0000, 0, 0);
    step(0, 1, 16'h0050, 1, 0);
    chk("load_over_dec", 32'(vo[0]), 32'h0050);

    // Three-digit borrow
    step(0, 1, 16'h1000, 0, 0);
    step(0, 0, 16'h0000, 1, 0);
    chk("borrow_wrap", 32'(vo[0]), 32'h0999);

    // Auto-reload cycle from 0003
    step(0, 1, 16'h0003, 0, 0);
    to_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 16'h0000, 1, 0);
      to_cnt += int'(to_o[1]);
    end
    chk("reload_value", 32'(vo[1]), 32'h0002);
    chk("reload_pulses", 32'(to_cnt), 32'd2);

    // Clamp, hold, release
    step(0, 1, 16'h00F5, 0, 0);
    chk("clamp", 32'(vo[0]), 32'h0095);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0000, 1, 1);
    step(0, 0, 16'h0000, 1, 0);
    chk("hold_release", 32'(vo[0]), 32'h0094);

    // Reset wins over a coincident load, count does not resume
    step(0, 1, 16'h0042, 0, 0);
    step(1, 1, 16'h0099, 1, 0);
    step(0, 0, 16'h0000, 1, 0);
    chk("post_reset", 32'(vo[0]), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: rv = W'($urandom);
        default: rv = int2bcd(int'($urandom_range(0, 25)));
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0), rv,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
